// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: the NOP injected for
// out-of-range fetches, the PC step, the per-cycle action type and the
// byte-to-word address helper.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam int          PC_STEP        = 4;
    localparam int          MAX_ADDR_WIDTH = 64;

    // What the fetch stage does on a given clock edge
    typedef enum logic [1:0] {
        ACT_STALL,
        ACT_JUMP,
        ACT_FETCH,
        ACT_DRAIN
    } fetch_action_e;

    // Word index of a byte address (drops the two byte-offset bits)
    function automatic logic [MAX_ADDR_WIDTH-1:0] word_index(
        input logic [MAX_ADDR_WIDTH-1:0] byte_addr
    );
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Instruction RAM: synchronous read with enable, independent write port.
// A read and write of the same index in one cycle returns the old word.
// Only the read register is reset; the data array keeps its contents.
module instr_ram
    import fetch_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 128,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // Program-load write port, no reset on the array
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; sees the pre-write contents on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, instruction RAM and a registered
// valid/ready output towards decode. Jumps flush the held output, a busy
// decode stalls everything, and fetches outside the RAM return a NOP with
// out_fault set so decode can raise the trap.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_WIDTH = 32,
    parameter int              WORD_WIDTH = 32,
    parameter int              DEPTH      = 128,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    localparam int             IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_fault,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [MAX_ADDR_WIDTH-1:0] pc_word;
    logic                      in_range;
    logic                      advance;
    logic                      rd_en;
    logic [WORD_WIDTH-1:0]     ram_rdata;
    fetch_action_e             action;

    assign pc_word  = word_index(MAX_ADDR_WIDTH'(pc));
    assign in_range = (pc_word < MAX_ADDR_WIDTH'(DEPTH));
    assign advance  = ~out_valid | out_ready;

    // Choose this cycle's action: jump beats fetch, a full output stalls
    always_comb begin
        action = ACT_STALL;
        if (jump_valid) begin
            action = ACT_JUMP;
        end else if (advance) begin
            action = fetch_en ? ACT_FETCH : ACT_DRAIN;
        end
    end

    // Only touch the RAM for in-range fetches so a held word stays put
    assign rd_en = (action == ACT_FETCH) & in_range & ~rst;

    instr_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rd_addr (pc_word[IDX_W-1:0]),
        .rd_data (ram_rdata),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // PC and output registers; reset wins over everything, including jumps
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_fault <= 1'b0;
        end else begin
            case (action)
                ACT_JUMP: begin
                    pc        <= {jump_target[ADDR_WIDTH-1:2], 2'b00};
                    out_valid <= 1'b0;
                end
                ACT_FETCH: begin
                    pc        <= pc + ADDR_WIDTH'(PC_STEP);
                    out_pc    <= pc;
                    out_fault <= ~in_range;
                    out_valid <= 1'b1;
                end
                ACT_DRAIN: begin
                    out_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // A faulting fetch presents the NOP; the RAM register keeps its old word
    assign out_instr = out_fault ? WORD_WIDTH'(NOP_INSTR) : ram_rdata;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed test-plan steps followed
// by a randomized phase, all checked against a cycle-level behavioural model.
module tb_instr_fetch_unit;

    localparam int DEPTH = 128;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic [31:0] pc;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_out_pc;
    logic        m_fault;

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .WORD_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_fault   (out_fault),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic checkOne(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_valid});
        checkOne({tag, ".out_pc"},    out_pc,             m_out_pc);
        checkOne({tag, ".out_fault"}, {31'b0, out_fault}, {31'b0, m_fault});
        checkOne({tag, ".out_instr"}, out_instr,          m_instr);
        checkOne({tag, ".pc"},        pc,                 m_pc);
    endtask

    // One clock: the model follows the behavioural rules, then outputs are compared
    task automatic applyStimulus(input string tag);
        int unsigned widx;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_out_pc = 32'h0; m_fault = 1'b0;
        end else if (jump_valid) begin
            m_pc    = jump_target & 32'hFFFF_FFFC;
            m_valid = 1'b0;
        end else if (!m_valid || out_ready) begin
            if (fetch_en) begin
                widx     = m_pc / 4;
                m_fault  = (widx >= DEPTH);
                m_instr  = m_fault ? NOP : m_mem[widx];
                m_out_pc = m_pc;
                m_valid  = 1'b1;
                m_pc     = m_pc + 32'd4;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
        #1;
        checkOutput(tag);
    endtask

    task automatic setIn(input logic r, input logic fe, input logic rdy,
                         input logic ju, input logic [31:0] jt);
        rst = r; fetch_en = fe; out_ready = rdy; jump_valid = ju; jump_target = jt;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    initial begin
        logic [31:0] x_word;
        logic [31:0] y_word;
        x_word = 32'hCAFE_0005;
        y_word = 32'hBEEF_0505;

        // Reset, with a jump that must be ignored, while loading the whole RAM
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
        applyStimulus("reset");
        jump_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = 7'(i);
            wr_data = (i == 5) ? x_word : $urandom;
            applyStimulus("load");
        end
        $display("[TB] RAM loaded");

        // Sequential fetch 0,4,8,12 with decode always ready
        setIn(1'b0, 1'b1, 1'b1, 1'b0, '0);
        applyStimulus("seq0");
        applyStimulus("seq4");

        // Stall three cycles while out_pc=4, then release
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("stall");
        out_ready = 1'b1;
        applyStimulus("release8");
        applyStimulus("seq12");

        // Jump flush with valid held and decode not ready
        out_ready = 1'b0;
        jump_valid = 1'b1; jump_target = 32'h23;
        applyStimulus("jump_flush");
        jump_valid = 1'b0; out_ready = 1'b1;
        applyStimulus("after_jump");

        // Out-of-range fetch yields a faulting NOP, fetching continues
        jump_valid = 1'b1; jump_target = 32'h200;
        applyStimulus("jump_oor");
        jump_valid = 1'b0;
        applyStimulus("oor0");
        applyStimulus("oor1");

        // PC wrap at the top of the address space
        jump_valid = 1'b1; jump_target = 32'hFFFF_FFFE;
        applyStimulus("jump_top");
        jump_valid = 1'b0;
        applyStimulus("top");
        applyStimulus("wrapped");

        // Read/write collision on word 5 returns the old word, refetch the new
        jump_valid = 1'b1; jump_target = 32'h14;
        applyStimulus("jump_14");
        jump_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 7'd5; wr_data = y_word;
        applyStimulus("collide");
        wr_en = 1'b0;
        jump_valid = 1'b1; jump_target = 32'h14;
        applyStimulus("rejump_14");
        jump_valid = 1'b0;
        applyStimulus("refetch");

        // Drain with fetch disabled
        fetch_en = 1'b0;
        applyStimulus("drain");
        applyStimulus("idle");

        // Reset while stalled on out_pc=8, RAM must survive
        setIn(1'b0, 1'b0, 1'b1, 1'b1, 32'h8);
        applyStimulus("jump_8");
        jump_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
        applyStimulus("hold8");
        applyStimulus("hold8b");
        rst = 1'b1;
        applyStimulus("reset_mid");
        rst = 1'b0; out_ready = 1'b1;
        applyStimulus("post_reset0");
        applyStimulus("post_reset4");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            jump_valid  = ($urandom_range(0, 9) == 0);
            jump_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 'h27F));
            fetch_en    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            wr_en       = ($urandom_range(0, 3) == 0);
            wr_addr     = 7'($urandom_range(0, DEPTH - 1));
            wr_data     = $urandom;
            applyStimulus("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
